// File: rtl/pooling_pkg.sv
// Shared state type, geometry defaults and width helper for the pooling input packer.
// DATA_WIDTH normally comes from global_define.v; a fallback is supplied when it is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package pooling_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } packer_state_t;

    // Bits needed to index 0..value-1, never less than one bit.
    function automatic int unsigned logb2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    localparam int unsigned DEF_INPUT_SIZE     = 6;
    localparam int unsigned DEF_KERNEL_SIZE    = 2;
    localparam int unsigned DEF_TOTAL_FEATURE  = 4;

    localparam int unsigned POOL_ROW_WIDTH     = logb2(DEF_INPUT_SIZE);
    localparam int unsigned POOL_COL_WIDTH     = logb2(DEF_INPUT_SIZE);
    localparam int unsigned POOL_FEATURE_WIDTH = logb2(DEF_TOTAL_FEATURE);
    localparam int unsigned WORDS_PER_FRAME    =
        (DEF_INPUT_SIZE / DEF_KERNEL_SIZE) * DEF_INPUT_SIZE * DEF_TOTAL_FEATURE;

endpackage

// File: rtl/pooling_pos_counter.sv
// Cascaded column -> row -> feature position counter for one raster-ordered frame.
// Exposes the row/feature of the current pixel plus column-wrap and last-pixel flags.
module pooling_pos_counter
    import pooling_pkg::*;
#(
    parameter int unsigned INPUT_SIZE    = DEF_INPUT_SIZE,
    parameter int unsigned TOTAL_FEATURE = DEF_TOTAL_FEATURE,
    localparam int unsigned COL_WIDTH     = logb2(INPUT_SIZE),
    localparam int unsigned ROW_WIDTH     = logb2(INPUT_SIZE),
    localparam int unsigned FEATURE_WIDTH = logb2(TOTAL_FEATURE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     en_i,
    output logic [ROW_WIDTH-1:0]     row_o,
    output logic [FEATURE_WIDTH-1:0] feature_o,
    output logic                     col_wrap_c,
    output logic                     last_pixel_c
);

    logic [COL_WIDTH-1:0]     col_q;
    logic [ROW_WIDTH-1:0]     row_q;
    logic [FEATURE_WIDTH-1:0] feat_q;
    logic                     row_last_c;
    logic                     feat_last_c;

    assign col_wrap_c   = (col_q == COL_WIDTH'(INPUT_SIZE - 1));
    assign row_last_c   = (row_q == ROW_WIDTH'(INPUT_SIZE - 1));
    assign feat_last_c  = (feat_q == FEATURE_WIDTH'(TOTAL_FEATURE - 1));
    assign last_pixel_c = col_wrap_c && row_last_c && feat_last_c;
    assign row_o        = row_q;
    assign feature_o    = feat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            feat_q <= '0;
        end else if (clear_i) begin
            col_q  <= '0;
            row_q  <= '0;
            feat_q <= '0;
        end else if (en_i) begin
            if (col_wrap_c) begin
                col_q <= '0;
                if (row_last_c) begin
                    row_q  <= '0;
                    feat_q <= feat_last_c ? '0 : feat_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pooling_input_packer.sv
// Packs KERNEL_SIZE adjacent conv pixels into one tagged word for the pooling channel.
// Optional sticky overrun flag when POOL_PACKER_OVERRUN_EN is defined.
module pooling_input_packer
    import pooling_pkg::*;
#(
    parameter int unsigned INPUT_SIZE    = DEF_INPUT_SIZE,
    parameter int unsigned KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int unsigned TOTAL_FEATURE = DEF_TOTAL_FEATURE,
    localparam int unsigned ROW_WIDTH     = logb2(INPUT_SIZE),
    localparam int unsigned FEATURE_WIDTH = logb2(TOTAL_FEATURE),
    localparam int unsigned DW            = `DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    input  logic                        pixel_valid,
    input  logic [DW-1:0]               pixel_in,
    output logic                        input_valid,
    output logic [KERNEL_SIZE*DW-1:0]   data_in,
    output logic [FEATURE_WIDTH-1:0]    feature_idx,
    output logic [ROW_WIDTH-1:0]        feature_row,
    output logic                        busy
`ifdef POOL_PACKER_OVERRUN_EN
    ,
    output logic                        overrun
`endif
);

    localparam int unsigned SLOT_WIDTH = logb2(KERNEL_SIZE);

    packer_state_t                    state_q;
    logic [KERNEL_SIZE-1:0][DW-1:0]   pack_q;
    logic [KERNEL_SIZE-1:0][DW-1:0]   pack_d;
    logic [SLOT_WIDTH-1:0]            slot_q;
    logic                             start_c;
    logic                             restart_c;
    logic                             accept_c;
    logic                             emit_c;
    logic                             col_wrap_c;
    logic                             last_pixel_c;
    logic [ROW_WIDTH-1:0]             row_c;
    logic [FEATURE_WIDTH-1:0]         feat_c;

    // A frame_start in ACTIVE wins over a same-cycle pixel.
    assign start_c   = (state_q == IDLE) && frame_start;
    assign restart_c = (state_q == ACTIVE) && frame_start;
    assign accept_c  = (state_q == ACTIVE) && pixel_valid && !frame_start;
    assign emit_c    = accept_c && (slot_q == SLOT_WIDTH'(KERNEL_SIZE - 1));

    always_comb begin
        pack_d         = pack_q;
        pack_d[slot_q] = pixel_in;
    end

    pooling_pos_counter #(
        .INPUT_SIZE    (INPUT_SIZE),
        .TOTAL_FEATURE (TOTAL_FEATURE)
    ) u_pos (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_c || restart_c),
        .en_i         (accept_c),
        .row_o        (row_c),
        .feature_o    (feat_c),
        .col_wrap_c   (col_wrap_c),
        .last_pixel_c (last_pixel_c)
    );

    // Frame FSM, pack register and registered outputs. busy spans ACTIVE and
    // the DONE drain cycle so it falls right after the final word's pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pack_q      <= '0;
            slot_q      <= '0;
            input_valid <= 1'b0;
            data_in     <= '0;
            feature_idx <= '0;
            feature_row <= '0;
            busy        <= 1'b0;
        end else begin
            input_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q <= ACTIVE;
                        busy    <= 1'b1;
                        pack_q  <= '0;
                        slot_q  <= '0;
                    end
                end
                ACTIVE: begin
                    if (restart_c) begin
                        pack_q <= '0;
                        slot_q <= '0;
                    end else if (accept_c) begin
                        pack_q <= pack_d;
                        // Trailing columns that cannot fill a word are dropped at row wrap.
                        slot_q <= (emit_c || col_wrap_c) ? '0 : slot_q + 1'b1;
                        if (emit_c) begin
                            input_valid <= 1'b1;
                            data_in     <= pack_d;
                            feature_idx <= feat_c;
                            feature_row <= row_c;
                        end
                        if (last_pixel_c) state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef POOL_PACKER_OVERRUN_EN
    // Sticky flag for pixels arriving while no frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (start_c || restart_c) begin
            overrun <= 1'b0;
        end else if (pixel_valid && (state_q != ACTIVE)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pooling_input_packer.sv
// Directed bench for pooling_input_packer: 6x6x4 frames on one instance, 5x5x4 on another.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_pooling_input_packer;

    localparam int unsigned DW = `DATA_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          fs_a, pv_a, fs_b, pv_b;
    logic [DW-1:0] px_a, px_b;
    logic          iv_a, iv_b, busy_a, busy_b;
    logic [2*DW-1:0] din_a, din_b;
    logic [1:0]    fi_a, fi_b;
    logic [2:0]    fr_a, fr_b;
`ifdef POOL_PACKER_OVERRUN_EN
    logic          ov_a, ov_b;
`endif

    int n_cmp;
    int n_err;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    pooling_input_packer #(.INPUT_SIZE(6), .KERNEL_SIZE(2), .TOTAL_FEATURE(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (fs_a),
        .pixel_valid (pv_a),
        .pixel_in    (px_a),
        .input_valid (iv_a),
        .data_in     (din_a),
        .feature_idx (fi_a),
        .feature_row (fr_a),
        .busy        (busy_a)
`ifdef POOL_PACKER_OVERRUN_EN
        ,
        .overrun     (ov_a)
`endif
    );

    pooling_input_packer #(.INPUT_SIZE(5), .KERNEL_SIZE(2), .TOTAL_FEATURE(4)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (fs_b),
        .pixel_valid (pv_b),
        .pixel_in    (px_b),
        .input_valid (iv_b),
        .data_in     (din_b),
        .feature_idx (fi_b),
        .feature_row (fr_b),
        .busy        (busy_b)
`ifdef POOL_PACKER_OVERRUN_EN
        ,
        .overrun     (ov_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every emitted word as {feature, row, data}.
    always @(posedge clk) begin
        #2;
        if (iv_a) qa.push_back(64'({fi_a, fr_a, din_a}));
        if (iv_b) qb.push_back(64'({fi_b, fr_b, din_b}));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input bit fs, input bit pv, input logic [DW-1:0] px);
        if (b) begin fs_b = fs; pv_b = pv; px_b = px; end
        else   begin fs_a = fs; pv_a = pv; px_a = px; end
    endtask

    task automatic start(input bit b);
        drive(b, 1'b1, 1'b0, '0);
        cyc();
        drive(b, 1'b0, 1'b0, '0);
    endtask

    // Send n pixels valued base+i; optional idle gap after each and pulse-timing checks.
    task automatic send(input bit b, input int n, input int base, input bit gap, input bit tchk);
        for (int i = 0; i < n; i++) begin
            drive(b, 1'b0, 1'b1, DW'(base + i));
            cyc();
            if (tchk) check($sformatf("pulse_after_px%0d", i), 64'(b ? iv_b : iv_a), 64'((i % 6) % 2));
            if (gap) begin
                drive(b, 1'b0, 1'b0, '0);
                cyc();
                if (tchk) check($sformatf("quiet_gap_px%0d", i), 64'(b ? iv_b : iv_a), 64'd0);
            end
        end
        drive(b, 1'b0, 1'b0, '0);
    endtask

    // Reference word k of a frame of size x size x 4 whose pixels are base+raster_index.
    function automatic logic [63:0] exp_word(input int size, input int k, input int base);
        int wpr, per_feat, f, r, p, n0;
        wpr      = size / 2;
        per_feat = wpr * size;
        f        = k / per_feat;
        r        = (k % per_feat) / wpr;
        p        = k % wpr;
        n0       = f * size * size + r * size + 2 * p;
        return 64'({2'(f), 3'(r), DW'(base + n0 + 1), DW'(base + n0)});
    endfunction

    task automatic check_words(input bit b, input string tag, input int size, input int base, input int count);
        int got_n;
        got_n = b ? qb.size() : qa.size();
        check({tag, "_word_count"}, 64'(got_n), 64'(count));
        for (int k = 0; k < count && k < got_n; k++)
            check($sformatf("%s_word%0d", tag, k), b ? qb[k] : qa[k], exp_word(size, k, base));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
        #12;
        check("rst_input_valid", 64'(iv_a), 64'd0);
        check("rst_data_in", 64'(din_a), 64'd0);
        check("rst_feature_idx", 64'(fi_a), 64'd0);
        check("rst_feature_row", 64'(fr_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Basic frame, back-to-back pixels 0..143.
        start(1'b0);
        check("t1_busy_after_start", 64'(busy_a), 64'd1);
        qa.delete();
        send(1'b0, 144, 0, 1'b0, 1'b0);
        check("t1_last_pulse", 64'(iv_a), 64'd1);
        check("t1_busy_in_drain", 64'(busy_a), 64'd1);
        cyc();
        check("t1_busy_dropped", 64'(busy_a), 64'd0);
        check("t1_pulse_single", 64'(iv_a), 64'd0);
        check_words(1'b0, "t1", 6, 0, 72);
        check("t1_first_word", qa.size() > 0 ? qa[0] : 64'hDEAD, 64'({2'd0, 3'd0, DW'(1), DW'(0)}));
        check("t1_last_word", qa.size() > 0 ? qa[qa.size()-1] : 64'hDEAD,
              64'({2'd3, 3'd5, DW'(143), DW'(142)}));
        cyc();

        // Gapped input with per-pixel pulse timing.
        start(1'b0);
        qa.delete();
        send(1'b0, 144, 0, 1'b1, 1'b1);
        cyc();
        cyc();
        check_words(1'b0, "t2", 6, 0, 72);

        // Restart after 37 pixels; the pixel on the restart cycle must be dropped.
        start(1'b0);
        send(1'b0, 37, 0, 1'b0, 1'b0);
        qa.delete();
        drive(1'b0, 1'b1, 1'b1, DW'(8'hEE));
        cyc();
        check("t3_no_emit_on_restart", 64'(iv_a), 64'd0);
        check("t3_busy_on_restart", 64'(busy_a), 64'd1);
        send(1'b0, 144, 100, 1'b0, 1'b0);
        cyc();
        cyc();
        check_words(1'b0, "t3", 6, 100, 72);

        // Reset mid-frame with pixel 11 pending.
        start(1'b0);
        send(1'b0, 11, 0, 1'b0, 1'b0);
        check("t4_word_before_reset", 64'(din_a), 64'({DW'(9), DW'(8)}));
        check("t4_row_before_reset", 64'(fr_a), 64'd1);
        qa.delete();
        drive(1'b0, 1'b0, 1'b1, DW'(11));
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_input_valid", 64'(iv_a), 64'd0);
        check("t4_rst_data_in", 64'(din_a), 64'd0);
        check("t4_rst_feature_row", 64'(fr_a), 64'd0);
        check("t4_rst_feature_idx", 64'(fi_a), 64'd0);
        check("t4_rst_busy", 64'(busy_a), 64'd0);
        cyc();
        #3;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        cyc();
        cyc();
        check("t4_no_partial_word", 64'(qa.size()), 64'd0);

        // Odd size on the 5x5 instance; frame_start during DONE is ignored.
        start(1'b1);
        qb.delete();
        send(1'b1, 100, 0, 1'b0, 1'b0);
        check("t6_busy_in_drain", 64'(busy_b), 64'd1);
        drive(1'b1, 1'b1, 1'b0, '0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, '0);
        check("t6_busy_after_done", 64'(busy_b), 64'd0);
        send(1'b1, 2, 200, 1'b0, 1'b0);
        cyc();
        cyc();
        check("t6_done_start_ignored", 64'(busy_b), 64'd0);
        check_words(1'b1, "t6", 5, 0, 40);
`ifdef POOL_PACKER_OVERRUN_EN
        check("t6_overrun_set", 64'(ov_b), 64'd1);
`endif

        // Pixels with no frame open.
        qa.delete();
        send(1'b0, 5, 50, 1'b0, 1'b0);
        cyc();
        cyc();
        check("t5_no_idle_words", 64'(qa.size()), 64'd0);
        check("t5_idle_busy", 64'(busy_a), 64'd0);
`ifdef POOL_PACKER_OVERRUN_EN
        check("t5_overrun_set", 64'(ov_a), 64'd1);
        start(1'b0);
        check("t5_overrun_cleared", 64'(ov_a), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
